mips32_debug_loader: RTL
========================

Name: mips32_debug_loader

Overview:
- Host-side debug/load controller for the pipelined MIPS32 core.
- Writes program and data words into the core's unified memory while the core is held, starts execution at a chosen PC and waits for HLT.
- Streams memory contents back to the host.
- Replaces hierarchical preloading and peeking with a handshaked command/response port usable in benches and on hardware.

Parameters:
ADDR_W, 10, word-address width of core memory (1024 words)
DATA_W, 32, memory word width
TIMEOUT, 1000, maximum RUN cycles before abort (width 16 bits)

Ports:
clk1  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0=WRITE, 1=READ, 2=RUN, 3=reserved
cmd_addr  in  ADDR_W  word address / start PC
cmd_data  in  DATA_W  write data (WRITE only)
cmd_len  in  8  READ burst length minus one
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_data  out  DATA_W  read word / cycle count / echoed address
rsp_status  out  2  0=OK, 1=TIMEOUT, 2=ERR
rsp_last  out  1  final beat of a response
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid one cycle after mem_addr
cpu_hold  out  1  forces core halted, PC frozen
cpu_start  out  1  one-cycle pulse: load PC, clear HALTED and BRANCH_TAKEN
cpu_pc  out  ADDR_W  PC value loaded on cpu_start
cpu_halted  in  1  core HALTED flag

Behaviour:
- Reset values: state IDLE, cmd_ready 0 in the reset cycle, all rsp_* 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, cpu_start 0, cpu_pc 0, counters 0.
- Reset is honoured in any state; it aborts any burst or RUN immediately, and cpu_hold re-asserts on the next edge.
- States: IDLE, WR, RD_ADDR, RD_WAIT, RD_RSP, RUN_GO, RUN_WAIT, RSP.
- cmd_ready=1 only in IDLE. Exactly one response transaction per command; commands never overlap.
- WRITE: on accept, the next cycle drives mem_we=1 (exactly one cycle) with mem_addr=cmd_addr and mem_wdata=cmd_data. Then RSP with rsp_data=addr zero-extended, status OK, last=1.
- READ:
  - Burst of cmd_len+1 words starting at cmd_addr.
  - Address increments modulo 2^ADDR_W; 1023 wraps to 0.
  - Per word: RD_ADDR drives mem_addr; RD_WAIT registers mem_rdata; RD_RSP holds rsp_valid/rsp_data stable until rsp_ready.
  - rsp_last=1 on the final beat only.
  - Minimum 3 cycles per word. Backpressure stalls indefinitely without loss.
- RUN:
  - RUN_GO: cpu_pc=cmd_addr, cpu_start=1 for exactly one cycle, cpu_hold drops to 0 the same cycle.
  - RUN_WAIT increments a cycle counter each cycle. cpu_halted is ignored in the first 2 RUN_WAIT cycles because HALTED is still clearing.
  - On cpu_halted: cpu_hold=1, RSP with rsp_data=count, status OK.
  - If the count reaches TIMEOUT first: cpu_hold=1, status TIMEOUT, rsp_data=TIMEOUT.
  - Halt and timeout in the same cycle reports OK.
- op=3: no memory or CPU activity; RSP with status ERR, data 0, last=1.
- mem_we is never asserted while cpu_hold=0.
- rsp_valid deasserts the cycle after a valid&ready handshake on the last beat, and the unit returns to IDLE.

Decomposition:
- Shared package mips32_dbg_pkg holds:
  - op codes (OP_WRITE/OP_READ/OP_RUN)
  - status codes (ST_OK/ST_TIMEOUT/ST_ERR)
  - state encoding
  - HLT opcode constant 6'h3f, for benches
- One natural sub-module: mips32_dbg_rsp_reg, a single-entry valid/ready output register holding data/status/last.

Test Plan:
- Reset mid-READ (after 2 of 5 beats) -> rsp_valid 0 and cpu_hold 1 next cycle; IDLE with cmd_ready 1 the cycle after.
- WRITE memory[0..7] = 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000, plus WRITE memory[120]=85 -> nine OK responses echoing the addresses, one mem_we pulse each.
- RUN addr 0 -> single cpu_start pulse with cpu_pc=0; cpu_halted after HLT -> status OK, nonzero count, cpu_hold re-asserted. Follow with READ addr 120 len 1 -> beats 85, 130, last on the second.
- READ addr 1022 len 3 with rsp_ready toggling every other cycle -> words from 1022, 1023, 0, 1 in order, data stable while stalled.
- RUN with a program lacking HLT (memory all 0c631800), TIMEOUT=50 -> status TIMEOUT, rsp_data 50, cpu_hold 1.
- cmd_op=3 -> status ERR, no mem_we or cpu_start.

Source files
------------

// File: rtl/mips32_dbg_pkg.sv
// rtl/mips32_dbg_pkg.sv - shared constants and state encoding for the MIPS32 debug loader
//
// Purpose: command op codes, response status codes, loader FSM state type and
// the core's HLT opcode (useful to benches building programs).
// Ports: none (package).
package mips32_dbg_pkg;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;

  localparam logic [5:0] HLT_OPCODE = 6'h3f;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ADDR  = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_RSP   = 3'd4,
    S_RUN_GO   = 3'd5,
    S_RUN_WAIT = 3'd6,
    S_RSP      = 3'd7
  } state_t;

endpackage

// File: rtl/mips32_dbg_rsp_reg.sv
// rtl/mips32_dbg_rsp_reg.sv - single-entry valid/ready response output register
//
// Purpose: holds one response beat (data/status/last) stable until the host
// takes it.
// Ports:
//   clk1, rst            clock, synchronous active-high reset
//   load                 capture load_* and raise rsp_valid
//   load_data/status/last  beat contents to capture
//   rsp_valid/ready      output handshake
//   rsp_data/status/last registered beat contents
module mips32_dbg_rsp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [1:0]        load_status,
  input  logic              load_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              rsp_last
);

  always_ff @(posedge clk1) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= '0;
      rsp_last   <= 1'b0;
    end else if (load) begin
      // A new beat takes priority; the controller never loads while a beat is pending.
      rsp_valid  <= 1'b1;
      rsp_data   <= load_data;
      rsp_status <= load_status;
      rsp_last   <= load_last;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/mips32_debug_loader.sv
// rtl/mips32_debug_loader.sv - host command/response debug and load controller for the MIPS32 core
//
// Purpose: writes and reads the core's unified memory while the core is held,
// starts the core at a chosen PC and waits for HLT (or a timeout).
// Ports:
//   clk1, rst                      clock, synchronous active-high reset
//   cmd_valid/ready, cmd_op/addr/data/len   host command port
//   rsp_valid/ready, rsp_data/status/last   host response port
//   mem_we/addr/wdata, mem_rdata   core memory port (rdata one cycle after addr)
//   cpu_hold, cpu_start, cpu_pc, cpu_halted  core run control
module mips32_debug_loader
  import mips32_dbg_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [7:0]        cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              rsp_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_halted
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_q;
  logic [15:0]       count_q;
  logic [15:0]       count_inc;

  logic              ld;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        ld_status;
  logic              ld_last;
  logic              rsp_fire;

  assign count_inc = count_q + 16'd1;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Memory and PC outputs come straight from the latched command fields, so
  // they are zero out of reset and stable for the whole command.
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign cpu_pc    = pc_q;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    cpu_start = 1'b0;
    cpu_hold  = 1'b1;
    ld        = 1'b0;
    ld_data   = '0;
    ld_status = ST_OK;
    ld_last   = 1'b1;
    unique case (state)
      S_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          unique case (cmd_op)
            OP_WRITE: state_n = S_WR;
            OP_READ:  state_n = S_RD_ADDR;
            OP_RUN:   state_n = S_RUN_GO;
            default: begin
              ld        = 1'b1;
              ld_status = ST_ERR;
              state_n   = S_RSP;
            end
          endcase
        end
      end
      S_WR: begin
        mem_we  = 1'b1;
        ld      = 1'b1;
        ld_data = DATA_W'(addr_q);
        state_n = S_RSP;
      end
      S_RD_ADDR: begin
        state_n = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        ld      = 1'b1;
        ld_data = mem_rdata;
        ld_last = (beat_q == len_q);
        state_n = S_RD_RSP;
      end
      S_RD_RSP: begin
        if (rsp_fire) begin
          state_n = rsp_last ? S_IDLE : S_RD_ADDR;
        end
      end
      S_RUN_GO: begin
        cpu_start = 1'b1;
        cpu_hold  = 1'b0;
        state_n   = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        cpu_hold = 1'b0;
        // count_q is the number of completed RUN_WAIT cycles; the first two
        // are skipped because the core's HALTED flag is still clearing.
        // Halt is tested before timeout so a tie reports OK.
        if (count_q >= 16'd2 && cpu_halted) begin
          ld       = 1'b1;
          ld_data  = DATA_W'(count_inc);
          state_n  = S_RSP;
          cpu_hold = 1'b1;
        end else if (count_inc >= TIMEOUT_CNT) begin
          ld        = 1'b1;
          ld_data   = DATA_W'(TIMEOUT_CNT);
          ld_status = ST_TIMEOUT;
          state_n   = S_RSP;
          cpu_hold  = 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_fire) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      addr_q  <= '0;
      pc_q    <= '0;
      data_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            beat_q  <= '0;
            count_q <= '0;
            if (cmd_op == OP_WRITE) data_q <= cmd_data;
            if (cmd_op == OP_RUN)   pc_q   <= cmd_addr;
          end
        end
        S_RD_RSP: begin
          // Address wraps naturally at the ADDR_W boundary.
          if (rsp_fire && !rsp_last) begin
            addr_q <= addr_q + 1'b1;
            beat_q <= beat_q + 8'd1;
          end
        end
        S_RUN_WAIT: count_q <= count_inc;
        default: ;
      endcase
    end
  end

  mips32_dbg_rsp_reg #(.DATA_W(DATA_W)) u_rsp_reg (
    .clk1        (clk1),
    .rst         (rst),
    .load        (ld),
    .load_data   (ld_data),
    .load_status (ld_status),
    .load_last   (ld_last),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .rsp_last    (rsp_last)
  );

endmodule
